// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/exec/mem/wb on a
// shared datapath, with a DM handshake timeout and a retired counter.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_write,
    output logic [2:0]       dm_op,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ADD, C_SUB, C_SLL, C_JR, C_ORI, C_LUI,
        C_LD, C_ST, C_BEQ, C_BNE, C_JAL
    } cls_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [5:0]       r_funct;
    logic [TW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_retired;
    cls_t             w_cls_in;
    cls_t             w_cls;
    logic             w_retire;
    logic             w_tmo;
    logic             w_taken;
    logic             w_rtype;

    function automatic cls_t f_class(input logic [5:0] o, input logic [5:0] f);
        cls_t c;
        case (o)
            6'h00: begin
                case (f)
                    6'h20:   c = C_ADD;
                    6'h22:   c = C_SUB;
                    6'h00:   c = C_SLL;
                    6'h08:   c = C_JR;
                    default: c = C_ILL;
                endcase
            end
            6'h0d:               c = C_ORI;
            6'h0f:               c = C_LUI;
            6'h23, 6'h20, 6'h21: c = C_LD;
            6'h2b, 6'h28, 6'h29: c = C_ST;
            6'h04:               c = C_BEQ;
            6'h05:               c = C_BNE;
            6'h03:               c = C_JAL;
            default:             c = C_ILL;
        endcase
        return c;
    endfunction

    // DECODE classifies the live IR; every later state uses the latched copy
    assign w_cls_in = f_class(op, funct);
    assign w_cls    = f_class(r_op, r_funct);
    assign w_tmo    = (r_cnt == TW'(MEM_TIMEOUT - 1));
    assign w_rtype  = (w_cls == C_ADD) || (w_cls == C_SUB) || (w_cls == C_SLL);
    assign w_taken  = ((w_cls == C_BEQ) && zero) || ((w_cls == C_BNE) && !zero);

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        unique case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (w_cls_in)
                    C_ILL:        w_next = S_FETCH;
                    C_BEQ, C_BNE: w_next = S_BRANCH;
                    C_JAL, C_JR:  w_next = S_JUMP;
                    default:      w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if ((w_cls == C_LD) || (w_cls == C_ST)) w_next = S_MEM;
                else                                     w_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (w_cls == C_LD) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_next = S_FETCH;
                end
            end
            S_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= 6'd0;
            r_funct   <= 6'd0;
            r_cnt     <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= op;
                r_funct <= funct;
            end
            if (r_state == S_MEM) begin
                r_cnt <= (w_next == S_MEM) ? r_cnt + TW'(1) : '0;
            end
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        dm_op      = 3'd0;
        alu_src    = 1'b0;
        alu_op     = 4'b0000;
        ext_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: illegal = (w_cls_in == C_ILL);
            S_EXEC: begin
                alu_src = !w_rtype;
                case (w_cls)
                    C_SUB:   alu_op = 4'b0011;
                    C_SLL:   alu_op = 4'b0100;
                    C_ORI:   alu_op = 4'b0001;
                    default: alu_op = 4'b0010;
                endcase
                case (w_cls)
                    C_LUI:      ext_op = 2'b10;
                    C_LD, C_ST: ext_op = 2'b01;
                    default:    ext_op = 2'b00;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (w_cls == C_ST);
                mem_err   = w_tmo && !mem_ready;
                case (r_op)
                    6'h20:   dm_op = 3'd1;
                    6'h21:   dm_op = 3'd2;
                    6'h28:   dm_op = 3'd3;
                    6'h29:   dm_op = 3'd4;
                    default: dm_op = 3'd0;
                endcase
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = w_rtype ? 2'b01 : 2'b00;
                mem_to_reg = (w_cls == C_LD) ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alu_op   = 4'b0011;
                ext_op   = 2'b01;
                pc_write = w_taken;
                pc_src   = w_taken ? 2'b01 : 2'b00;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                if (w_cls == C_JAL) begin
                    pc_src     = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end else begin
                    pc_src = 2'b11;
                end
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed plan items plus random instruction stream
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_ctrl;

    localparam int T  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          ir_write;
    logic          mem_req;
    logic          mem_write;
    logic [2:0]    dm_op;
    logic          alu_src;
    logic [3:0]    alu_op;
    logic [1:0]    ext_op;
    logic          reg_write;
    logic [1:0]    reg_dst;
    logic [1:0]    mem_to_reg;
    logic          illegal;
    logic          mem_err;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic [22:0]   obs;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_ret = 0;

    // cls: 0 R-alu, 1 I-alu, 2 load, 3 store, 4 beq, 5 bne, 6 jal, 7 jr, 8 illegal
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        logic [3:0] aop;
        logic [1:0] ext;
        logic [2:0] dm;
    } ins_t;

    ins_t tbl[17];

    mc_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_write(mem_write), .dm_op(dm_op),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_err(mem_err),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_src, ir_write, mem_req, mem_write, dm_op,
                  alu_src, alu_op, ext_op, reg_write, reg_dst, mem_to_reg,
                  illegal, mem_err};

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    function automatic logic [22:0] exp_vec(input int s, input ins_t in,
                                            input logic z, input logic rdy,
                                            input logic tmo);
        logic pw, ir, mr, mw, as, rw, il, me, tk;
        logic [1:0] ps, ext, rd, m2r;
        logic [2:0] dm;
        logic [3:0] aop;
        {pw, ir, mr, mw, as, rw, il, me} = '0;
        {ps, ext, rd, m2r} = '0;
        dm = '0;
        aop = '0;
        case (s)
            1: begin ir = 1; pw = 1; end
            2: il = (in.cls == 8);
            3: begin as = (in.cls != 0); aop = in.aop; ext = in.ext; end
            4: begin
                mr = 1; mw = (in.cls == 3); dm = in.dm; me = tmo & ~rdy;
            end
            5: begin
                rw = 1;
                rd = (in.cls == 0) ? 2'b01 : 2'b00;
                m2r = (in.cls == 2) ? 2'b01 : 2'b00;
            end
            6: begin
                aop = 4'b0011; ext = 2'b01;
                tk = ((in.cls == 4) && z) || ((in.cls == 5) && !z);
                pw = tk; ps = tk ? 2'b01 : 2'b00;
            end
            7: begin
                pw = 1;
                if (in.cls == 6) begin
                    ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10;
                end else begin
                    ps = 2'b11;
                end
            end
            default: ;
        endcase
        return {pw, ps, ir, mr, mw, dm, as, aop, ext, rw, rd, m2r, il, me};
    endfunction

    // Starts and ends at posedge+1 of a FETCH cycle.
    // rdy_at: MEM cycle (1-based) in which mem_ready rises; > T means never.
    task automatic do_instr(input int idx, input int zsel, input int rdy_at);
        ins_t in;
        int seq[$];
        int mj[$];
        bit ret;
        logic z, r, tm;
        in = tbl[idx];
        seq.push_back(1); mj.push_back(0);
        seq.push_back(2); mj.push_back(0);
        ret = (in.cls != 8);
        if (in.cls == 4 || in.cls == 5) begin
            seq.push_back(6); mj.push_back(0);
        end else if (in.cls == 6 || in.cls == 7) begin
            seq.push_back(7); mj.push_back(0);
        end else if (in.cls != 8) begin
            seq.push_back(3); mj.push_back(0);
            if (in.cls == 2 || in.cls == 3) begin
                for (int j = 1; j <= T; j++) begin
                    seq.push_back(4); mj.push_back(j);
                    if (j == rdy_at || j == T) break;
                end
                if (rdy_at > T) ret = 0;
                else if (in.cls == 2) begin
                    seq.push_back(5); mj.push_back(0);
                end
            end else begin
                seq.push_back(5); mj.push_back(0);
            end
        end
        for (int c = 0; c < seq.size(); c++) begin
            op    = (seq[c] == 2) ? in.op : 6'($urandom);
            funct = (seq[c] == 2) ? in.fn : 6'($urandom);
            z     = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            r     = (seq[c] == 4) ? (mj[c] == rdy_at) : 1'($urandom);
            tm    = (seq[c] == 4) && (mj[c] == T);
            zero      = z;
            mem_ready = r;
            #1;
            chk($sformatf("state[%0d.%0d]", idx, c), 32'(state), 32'(seq[c]));
            chk($sformatf("outs[%0d.%0d]", idx, c), 32'(obs),
                32'(exp_vec(seq[c], in, z, r, tm)));
            if (c == 0)
                chk($sformatf("retired[%0d]", idx), 32'(retired),
                    32'(model_ret % (1 << CW)));
            @(posedge clk);
            #1;
        end
        if (ret) model_ret++;
    endtask

    initial begin
        tbl[0]  = '{6'h00, 6'h20, 0, 4'b0010, 2'b00, 3'd0};
        tbl[1]  = '{6'h00, 6'h22, 0, 4'b0011, 2'b00, 3'd0};
        tbl[2]  = '{6'h00, 6'h00, 0, 4'b0100, 2'b00, 3'd0};
        tbl[3]  = '{6'h00, 6'h08, 7, 4'b0000, 2'b00, 3'd0};
        tbl[4]  = '{6'h0d, 6'h15, 1, 4'b0001, 2'b00, 3'd0};
        tbl[5]  = '{6'h0f, 6'h2a, 1, 4'b0010, 2'b10, 3'd0};
        tbl[6]  = '{6'h23, 6'h11, 2, 4'b0010, 2'b01, 3'd0};
        tbl[7]  = '{6'h20, 6'h07, 2, 4'b0010, 2'b01, 3'd1};
        tbl[8]  = '{6'h21, 6'h3c, 2, 4'b0010, 2'b01, 3'd2};
        tbl[9]  = '{6'h2b, 6'h01, 3, 4'b0010, 2'b01, 3'd0};
        tbl[10] = '{6'h28, 6'h22, 3, 4'b0010, 2'b01, 3'd3};
        tbl[11] = '{6'h29, 6'h30, 3, 4'b0010, 2'b01, 3'd4};
        tbl[12] = '{6'h04, 6'h09, 4, 4'b0000, 2'b00, 3'd0};
        tbl[13] = '{6'h05, 6'h12, 5, 4'b0000, 2'b00, 3'd0};
        tbl[14] = '{6'h03, 6'h0c, 6, 4'b0000, 2'b00, 3'd0};
        tbl[15] = '{6'h3f, 6'h00, 8, 4'b0000, 2'b00, 3'd0};
        tbl[16] = '{6'h00, 6'h3f, 8, 4'b0000, 2'b00, 3'd0};

        reset = 1'b0;
        op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'(obs), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        reset = 1'b1;
        #1;
        chk("idle_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;

        do_instr(0, 2, 0);
        do_instr(4, 2, 0);
        chk("retired_two", 32'(retired), 32'd2);
        do_instr(6, 2, 3);
        do_instr(9, 2, T + 1);
        do_instr(12, 1, 0);
        do_instr(12, 0, 0);
        do_instr(13, 0, 0);
        do_instr(13, 1, 0);
        do_instr(15, 2, 0);
        do_instr(16, 2, 0);
        do_instr(2, 2, 0);
        do_instr(8, 2, T);
        for (int k = 0; k < 16; k++) do_instr(14, 2, 0);

        for (int k = 0; k < 300; k++)
            do_instr($urandom_range(0, 16), 2, $urandom_range(1, T + 1));

        op = 6'h2b; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_outs", 32'(obs), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("post_idle", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("post_fetch", 32'(state), 32'd1);
        chk("post_fetch_wr", 32'({ir_write, pc_write}), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
